alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 start  in  1  request; sampled on clk rising edge only when busy=0.
REQ-003 op  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
REQ-004 a, b  in  8 each  signed two's-complement operands.
REQ-005 busy  out  1  high while an operation executes.
REQ-006 done  out  1  one-cycle completion pulse.
REQ-007 result  out  16  signed result; held from done until the next accepted start.
REQ-008 ovf  out  1  8-bit signed overflow for ADD/SUB; 0 for MUL.
REQ-009 err  out  1  unsupported op flag, valid with done.
REQ-010 adder_x, adder_y  out  9 each; adder_cin  out  1: operands to the shared external 9-bit ripple adder.
REQ-011 adder_z  in  9; adder_cout  in  1: combinational sum and carry returned by that adder.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC, MUL, DONE; busy=1 in EXEC and MUL only.
REQ-013 In IDLE or DONE, start=1 at edge T SHALL latch a, b and op, then move to EXEC (op 00/01), MUL (op 10), or DONE with err=1 and result=0 (op 11).
REQ-014 start while busy=1 SHALL be ignored and SHALL NOT disturb latched operands.
REQ-015 EXEC: adder_x=sext9(a); adder_y=sext9(b) for ADD, ~sext9(b) for SUB; adder_cin=op[0].
REQ-016 At the end of EXEC: result=sext16(adder_z), ovf=adder_z[8]^adder_z[7], err=0; next state DONE (done high after edge T+1).
REQ-017 MUL SHALL run Booth radix-2 on a 9-bit accumulator A (initially 0), Q=b, Q-1=0, M=sext9(a), for exactly 8 cycles counted by a 3-bit counter.
REQ-018 Each MUL cycle: {Q[0],Q-1}=01 -> adder A+M; 10 -> adder A+~M, cin=1; 00/11 -> adder A+0, cin=0. Then {A,Q,Q-1} <= arithmetic shift right of {adder_z,Q,Q-1}.
REQ-019 After the 8th MUL cycle (edge T+8): result={A[7:0],Q}, ovf=0, err=0; next state DONE (done high after edge T+8).
REQ-020 DONE SHALL last one cycle; it returns to IDLE unless start=1, in which case it accepts back-to-back per REQ-013.
REQ-021 In IDLE and DONE, adder_x, adder_y and adder_cin SHALL be 0; adder_cout SHALL be ignored in all states.
REQ-022 The -128 x -128 case SHALL yield +16384 with no special handling.

Reset
REQ-023 rst=1 SHALL force IDLE immediately; busy, done, ovf and err SHALL be 0; result and counter SHALL be 0; adder outputs SHALL be 0.
REQ-024 Reset mid-EXEC or mid-MUL SHALL abort the operation with no done pulse; result SHALL read 0.

Configuration
REQ-025 Macro ALU_SEQ_MUL_EN defined: MUL state, counter and Booth registers SHALL be present; op 10 behaves per REQ-017 to REQ-019.
REQ-026 Macro ALU_SEQ_MUL_EN undefined: MUL logic SHALL be absent; op 10 SHALL behave like op 11 (done after edge T, err=1, result=0).

Verification
REQ-027 ADD a=100, b=27 -> result 0x007F, ovf=0, err=0, done high after edge T+1 only.
REQ-028 ADD a=100, b=28 -> result 0x0080, ovf=1; SUB a=-128, b=1 -> result 0xFF7F, ovf=1.
REQ-029 MUL a=-7, b=13 -> result 0xFFA5 after edge T+8; MUL a=-128, b=-128 -> 0x4000; busy=1 for exactly 8 cycles.
REQ-030 MUL active, start pulsed with new operands at cycle 4 -> ignored, result unchanged; rst at cycle 5 -> IDLE, no done, result 0.
REQ-031 op=11 -> err=1, result 0 after edge T; op=10 without ALU_SEQ_MUL_EN -> same response.
REQ-032 start held high continuously with ADD ops -> one result every 2 cycles, done pulses separated by one low cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ADD/SUB/MUL sequencer that drives a shared external 9-bit adder.
// Optional macro ALU_SEQ_MUL_EN adds the Booth radix-2 multiplier. Without it, op 10 reports err like op 11.
module alu_sequencer (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result,
  output logic              ovf,
  output logic              err,
  output logic [8:0]        adder_x,
  output logic [8:0]        adder_y,
  output logic              adder_cin,
  input  logic [8:0]        adder_z,
  input  logic              adder_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       sub_q;
  logic       accept;
  logic       bad_op;
  logic       unused_cout;

  // The carry out is not needed: overflow comes from the 9-bit sum itself.
  assign unused_cout = adder_cout;
  assign accept = start && (state == S_IDLE || state == S_DONE);

`ifdef ALU_SEQ_MUL_EN
  logic [8:0] acc;
  logic [7:0] q;
  logic       q_m1;
  logic [2:0] cnt;
  logic [8:0] m;
  logic [8:0] acc_nx;
  logic [7:0] q_nx;

  assign bad_op = (op == 2'b11);
  assign m      = {a_q[7], a_q};
  // Arithmetic shift right of {adder_z, Q, Q-1}.
  assign acc_nx = {adder_z[8], adder_z[8:1]};
  assign q_nx   = {adder_z[0], q[7:1]};
`else
  assign bad_op = op[1];
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (start) begin
          if (bad_op)     state_nx = S_DONE;
`ifdef ALU_SEQ_MUL_EN
          else if (op[1]) state_nx = S_MUL;
`endif
          else            state_nx = S_EXEC;
        end
      end
      S_EXEC: state_nx = S_DONE;
`ifdef ALU_SEQ_MUL_EN
      S_MUL: state_nx = (cnt == 3'd7) ? S_DONE : S_MUL;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // Status flags and adder operand selection.
  always_comb begin
    busy      = (state == S_EXEC) || (state == S_MUL);
    done      = (state == S_DONE);
    adder_x   = 9'd0;
    adder_y   = 9'd0;
    adder_cin = 1'b0;
    unique case (state)
      S_EXEC: begin
        adder_x   = {a_q[7], a_q};
        adder_y   = sub_q ? ~{b_q[7], b_q} : {b_q[7], b_q};
        adder_cin = sub_q;
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        adder_x = acc;
        unique case ({q[0], q_m1})
          2'b01: adder_y = m;
          2'b10: begin
            adder_y   = ~m;
            adder_cin = 1'b1;
          end
          default: adder_y = 9'd0;
        endcase
      end
`endif
      default: ;
    endcase
  end

  // Operand latches, Booth registers and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= 8'd0;
      b_q    <= 8'd0;
      sub_q  <= 1'b0;
      result <= 16'd0;
      ovf    <= 1'b0;
      err    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc    <= 9'd0;
      q      <= 8'd0;
      q_m1   <= 1'b0;
      cnt    <= 3'd0;
`endif
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        sub_q <= op[0];
        if (bad_op) begin
          result <= 16'd0;
          ovf    <= 1'b0;
          err    <= 1'b1;
        end
`ifdef ALU_SEQ_MUL_EN
        if (op == 2'b10) begin
          acc  <= 9'd0;
          q    <= b;
          q_m1 <= 1'b0;
          cnt  <= 3'd0;
        end
`endif
      end
      if (state == S_EXEC) begin
        result <= {{7{adder_z[8]}}, adder_z};
        ovf    <= adder_z[8] ^ adder_z[7];
        err    <= 1'b0;
      end
`ifdef ALU_SEQ_MUL_EN
      if (state == S_MUL) begin
        acc  <= acc_nx;
        q    <= q_nx;
        q_m1 <= q[0];
        cnt  <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          result <= {acc_nx[7:0], q_nx};
          ovf    <= 1'b0;
          err    <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized self-checking bench with an arithmetic reference model.
// Models the external 9-bit adder. Follows ALU_SEQ_MUL_EN for expected op 10 behaviour.
module tb_alu_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        op;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic              busy;
  logic              done;
  logic [15:0]       result;
  logic              ovf;
  logic              err;
  logic [8:0]        adder_x;
  logic [8:0]        adder_y;
  logic              adder_cin;
  logic [8:0]        adder_z;
  logic              adder_cout;
  logic [9:0]        sum;

  int n_cmp = 0;
  int n_bad = 0;

  alu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err),
    .adder_x(adder_x), .adder_y(adder_y), .adder_cin(adder_cin),
    .adder_z(adder_z), .adder_cout(adder_cout)
  );

  assign sum        = {1'b0, adder_x} + {1'b0, adder_y} + {9'd0, adder_cin};
  assign adder_z    = sum[8:0];
  assign adder_cout = sum[9];

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic; lat = edges after the accepting edge until done.
  function automatic void model(input logic [1:0] o,
                                input logic signed [7:0] x,
                                input logic signed [7:0] y,
                                output logic [15:0] r,
                                output logic ov, output logic er,
                                output int lat);
    int s;
    r = 16'd0; ov = 1'b0; er = 1'b1; lat = 0;
    case (o)
      2'b00: begin
        s = x + y; r = 16'(s); ov = (s > 127) || (s < -128); er = 1'b0; lat = 1;
      end
      2'b01: begin
        s = x - y; r = 16'(s); ov = (s > 127) || (s < -128); er = 1'b0; lat = 1;
      end
`ifdef ALU_SEQ_MUL_EN
      2'b10: begin
        s = x * y; r = 16'(s); ov = 1'b0; er = 1'b0; lat = 8;
      end
`endif
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o,
                        input logic signed [7:0] x,
                        input logic signed [7:0] y,
                        output int lat, output int nbusy,
                        output logic [15:0] r, output logic ov, output logic er,
                        output logic dn_next, output logic [15:0] r_next,
                        output logic adz,
                        output logic [8:0] ax, output logic [8:0] ay,
                        output logic ac, output bit tmo);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
    ax = adder_x; ay = adder_y; ac = adder_cin;
    lat = 0; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    tmo = !done;
    r = result; ov = ovf; er = err;
    adz = (adder_x == 9'd0) && (adder_y == 9'd0) && !adder_cin;
    @(posedge clk); #1;
    dn_next = done; r_next = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 8'd0; b = 8'd0;
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({busy, done, ovf, err} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got busy/done/ovf/err=%b exp 0000", {busy, done, ovf, err});
    end
    n_cmp++;
    if (result !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_result: got %h exp 0000", result);
    end
    n_cmp++;
    if ({adder_x, adder_y, adder_cin} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_adder: got x=%h y=%h cin=%b exp 0", adder_x, adder_y, adder_cin);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  t_op[6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [7:0]  t_a[6]  = '{8'h64, 8'h64, 8'h80, 8'hF9, 8'h80, 8'h05};
    logic [7:0]  t_b[6]  = '{8'h1B, 8'h1C, 8'h01, 8'h0D, 8'h80, 8'h05};
`ifdef ALU_SEQ_MUL_EN
    logic [15:0] t_r[6]  = '{16'h007F, 16'h0080, 16'hFF7F, 16'hFFA5, 16'h4000, 16'h0000};
    logic        t_e[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          t_l[6]  = '{1, 1, 1, 8, 8, 0};
`else
    logic [15:0] t_r[6]  = '{16'h007F, 16'h0080, 16'hFF7F, 16'h0000, 16'h0000, 16'h0000};
    logic        t_e[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          t_l[6]  = '{1, 1, 1, 0, 0, 0};
`endif
    logic        t_v[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int lat, nb;
    logic [15:0] r, rn;
    logic ov, er, dn, adz, ac;
    logic [8:0] ax, ay, eay;
    bit tmo;
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], lat, nb, r, ov, er, dn, rn, adz, ax, ay, ac, tmo);
      n_cmp++;
      if (tmo || r !== t_r[i] || er !== t_e[i]) begin
        n_bad++;
        $display("FAIL dir_result[%0d]: got r=%h err=%b tmo=%0d exp r=%h err=%b",
                 i, r, er, tmo, t_r[i], t_e[i]);
      end
      n_cmp++;
      if (!t_e[i] && ov !== t_v[i]) begin
        n_bad++;
        $display("FAIL dir_ovf[%0d]: got %b exp %b", i, ov, t_v[i]);
      end
      n_cmp++;
      if (lat != t_l[i] || nb != t_l[i]) begin
        n_bad++;
        $display("FAIL dir_latency[%0d]: got lat=%0d busy=%0d exp %0d", i, lat, nb, t_l[i]);
      end
      n_cmp++;
      if (dn !== 1'b0 || rn !== t_r[i] || adz !== 1'b1) begin
        n_bad++;
        $display("FAIL dir_pulse[%0d]: got done_next=%b held=%h adder_zero=%b exp 0 %h 1",
                 i, dn, rn, adz, t_r[i]);
      end
      if (t_op[i][1] == 1'b0) begin
        eay = {t_b[i][7], t_b[i]};
        if (t_op[i][0]) eay = ~eay;
        n_cmp++;
        if (ax !== {t_a[i][7], t_a[i]} || ay !== eay || ac !== t_op[i][0]) begin
          n_bad++;
          $display("FAIL dir_adder[%0d]: got x=%h y=%h cin=%b exp x=%h y=%h cin=%b",
                   i, ax, ay, ac, {t_a[i][7], t_a[i]}, eay, t_op[i][0]);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat, nb, elat;
    logic [15:0] r, rn, er16;
    logic ov, er, dn, adz, ac, eov, eer;
    logic [8:0] ax, ay;
    logic [1:0] o;
    logic signed [7:0] x, y;
    bit tmo;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = 8'($urandom);
      y = 8'($urandom);
      model(o, x, y, er16, eov, eer, elat);
      run_op(o, x, y, lat, nb, r, ov, er, dn, rn, adz, ax, ay, ac, tmo);
      n_cmp++;
      if (tmo || r !== er16 || er !== eer || (!eer && ov !== eov) || lat != elat
          || nb != elat || dn !== 1'b0 || rn !== er16) begin
        n_bad++;
        $display("FAIL rand[%0d] op=%b a=%0d b=%0d: got r=%h ovf=%b err=%b lat=%0d busy=%0d dn=%b held=%h exp r=%h ovf=%b err=%b lat=%0d",
                 i, o, x, y, r, ov, er, lat, nb, dn, rn, er16, eov, eer, elat);
      end
    end
  endtask

  task automatic test_abort();
    int lat, nb, ndone;
    logic [15:0] r, rn, held;
    logic ov, er, dn, adz, ac;
    logic [8:0] ax, ay;
    bit tmo;
    run_op(2'b00, 8'sd1, 8'sd2, lat, nb, r, ov, er, dn, rn, adz, ax, ay, ac, tmo);
    n_cmp++;
    if (r !== 16'h0003) begin
      n_bad++;
      $display("FAIL abort_setup: got %h exp 0003", r);
    end
    held = 16'h0003;
`ifdef ALU_SEQ_MUL_EN
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'hF9; b = 8'h0D;
    @(posedge clk); #1;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 4) begin
        start = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
      end else start = 1'b0;
      @(posedge clk); #1;
      if (c < 8 && done) ndone++;
    end
    n_cmp++;
    if (done !== 1'b1 || result !== 16'hFFA5 || ndone != 0) begin
      n_bad++;
      $display("FAIL ignored_start: got done=%b r=%h early=%0d exp 1 ffa5 0", done, result, ndone);
    end
    held = 16'hFFA5;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h05; b = 8'h06;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    start = 1'b0;
`else
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'sd50; b = 8'sd50;
    @(posedge clk); #1;
    start = 1'b0;
`endif
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== held) begin
      n_bad++;
      $display("FAIL abort_busy: got busy=%b done=%b r=%h exp 1 0 %h", busy, done, result, held);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_reset: got busy=%b done=%b r=%h err=%b exp 0 0 0000 0",
               busy, done, result, err);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone != 0 || result !== 16'h0000) begin
      n_bad++;
      $display("FAIL abort_no_done: got active=%0d r=%h exp 0 0000", ndone, result);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]        bo[13];
    logic signed [7:0] ba[13];
    logic signed [7:0] bb[13];
    logic [15:0] er16;
    logic eov, eer;
    int elat;
    @(negedge clk);
    bo[0] = 2'($urandom_range(0, 1)); ba[0] = 8'($urandom); bb[0] = 8'($urandom);
    start = 1'b1; op = bo[0]; a = ba[0]; b = bb[0];
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 1) begin
        model(bo[k-1], ba[k-1], bb[k-1], er16, eov, eer, elat);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== er16 || ovf !== eov) begin
          n_bad++;
          $display("FAIL b2b_done[%0d]: got done=%b busy=%b r=%h ovf=%b exp 1 0 %h %b",
                   k, done, busy, result, ovf, er16, eov);
        end
      end else begin
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_gap[%0d]: got done=%b busy=%b exp 0 1", k, done, busy);
        end
      end
      @(negedge clk);
      bo[k+1] = 2'($urandom_range(0, 1)); ba[k+1] = 8'($urandom); bb[k+1] = 8'($urandom);
      op = bo[k+1]; a = ba[k+1]; b = bb[k+1];
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
